// File: rtl/mcp3_arb06_if.sv
// Request/grant bundle between the AFU requestors and the mcp3_arb06 round-robin arbiter.
// The master side raises requests; the slave side (the arbiter) returns grants and pointer status.
interface mcp3_arb06_if;
   logic [5:0] req;
   logic       inj_ptr_err;
   logic [5:0] gnt;
   logic       gnt_valid;
   logic [2:0] gnt_enc;
   logic [5:0] last_gnt;
   logic       ptr_err;

   modport master (
      output req, inj_ptr_err,
      input  gnt, gnt_valid, gnt_enc, last_gnt, ptr_err
   );

   modport slave (
      input  req, inj_ptr_err,
      output gnt, gnt_valid, gnt_enc, last_gnt, ptr_err
   );
endinterface

// File: rtl/mcp3_arb06.sv
// Six-way round-robin arbiter with grant hold and a max-hold fairness limit, plus a
// one-hot checker on the round-robin pointer feeding a sticky fault flag.

module mcp3_ohc06 (
   input  logic [5:0] vec,
   output logic       err
);
   // Zero and multi-hot both count as errors.
   assign err = (vec == 6'd0) || ((vec & 6'(vec - 6'd1)) != 6'd0);
endmodule

module mcp3_arb06 #(
   parameter int MAX_HOLD = 16
) (
   input  logic         clock,
   input  logic         reset,
   mcp3_arb06_if.slave  bus
);

   typedef enum logic {IDLE, OWN} state_t;

   localparam logic [7:0] HOLD_LIMIT = MAX_HOLD[7:0];

   state_t      state_q, state_d;
   logic [5:0]  gnt_q, gnt_d;
   logic [2:0]  enc_q, enc_d;
   logic [5:0]  last_q, last_d;
   logic [7:0]  hold_q, hold_d;
   logic        ptr_err_q;
   logic        chk_err;

   logic [5:0]  cand;
   logic [5:0]  winner;
   logic        owner_drop;
   logic        limit_hit;
   logic        release_now;

   // Scan starts just above the highest set pointer bit, so a corrupted pointer still
   // yields a deterministic order; an all-zero pointer behaves like bit 5.
   function automatic logic [5:0] rr_pick(input logic [5:0] c, input logic [5:0] ptr);
      logic [5:0] pick;
      int         start;
      int         idx;
      logic       done;
      start = 5;
      for (int i = 0; i < 6; i++) begin
         if (ptr[i]) start = i;
      end
      pick = 6'd0;
      done = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         idx = (start + k) % 6;
         if (!done && c[idx]) begin
            pick[idx] = 1'b1;
            done      = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic logic [2:0] encode(input logic [5:0] v);
      logic [2:0] e;
      e = 3'd0;
      for (int i = 0; i < 6; i++) begin
         if (v[i]) e = 3'(i);
      end
      return e;
   endfunction

   assign cand        = bus.req & ~gnt_q;
   assign winner      = rr_pick(cand, last_q);
   assign owner_drop  = (bus.req & gnt_q) == 6'd0;
   assign limit_hit   = (HOLD_LIMIT != 8'd0) && (hold_q >= HOLD_LIMIT) && (cand != 6'd0);
   assign release_now = owner_drop || limit_hit;

   mcp3_ohc06 u_ohc (
      .vec (last_q),
      .err (chk_err)
   );

   // State and all registered outputs; the sticky fault only clears on reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         gnt_q     <= 6'd0;
         enc_q     <= 3'd0;
         last_q    <= 6'b100000;
         hold_q    <= 8'd0;
         ptr_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         enc_q     <= enc_d;
         last_q    <= last_d;
         hold_q    <= hold_d;
         ptr_err_q <= ptr_err_q | chk_err;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus.req != 6'd0) state_d = OWN;
         OWN:  if (release_now && cand == 6'd0) state_d = IDLE;
      endcase
   end

   // Handover happens on the release edge itself so there is no idle gap between owners.
   always_comb begin
      gnt_d  = gnt_q;
      last_d = last_q;
      hold_d = hold_q;
      case (state_q)
         IDLE: begin
            if (bus.req != 6'd0) begin
               gnt_d  = winner;
               last_d = winner;
               hold_d = 8'd1;
            end
         end
         OWN: begin
            if (release_now) begin
               if (cand != 6'd0) begin
                  gnt_d  = winner;
                  last_d = winner;
                  hold_d = 8'd1;
               end else begin
                  gnt_d  = 6'd0;
                  hold_d = 8'd0;
               end
            end else if (hold_q != 8'hFF) begin
               hold_d = hold_q + 8'd1;
            end
         end
      endcase
      last_d[0] = last_d[0] ^ bus.inj_ptr_err;
      enc_d     = encode(gnt_d);
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_valid = |gnt_q;
   assign bus.gnt_enc   = enc_q;
   assign bus.last_gnt  = last_q;
   assign bus.ptr_err   = ptr_err_q;

endmodule

// File: tb/tb_mcp3_arb06.sv
// Directed bench for mcp3_arb06 (MAX_HOLD=4): handover, round-robin order, hold limit,
// pointer corruption with sticky fault, and reset mid-grant.
module tb_mcp3_arb06;

   logic clock = 1'b0;
   logic reset;
   int   vectors    = 0;
   int   miscompares = 0;
   int   held;

   mcp3_arb06_if bus ();

   mcp3_arb06 #(.MAX_HOLD(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_stimulus(input logic rst, input logic [5:0] r, input logic inj);
      reset           = rst;
      bus.req         = r;
      bus.inj_ptr_err = inj;
      tick();
   endtask

   task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_grant(input string tag, input logic [5:0] g, input logic [2:0] e);
      check_output({tag, "_gnt"}, 16'(bus.gnt), 16'(g));
      check_output({tag, "_enc"}, 16'(bus.gnt_enc), 16'(e));
      check_output({tag, "_valid"}, 16'(bus.gnt_valid), 16'(g != 6'd0));
   endtask

   initial begin
      reset = 1'b1;
      bus.req = 6'd0;
      bus.inj_ptr_err = 1'b0;

      // reset values
      apply_stimulus(1'b1, 6'd0, 1'b0);
      apply_stimulus(1'b1, 6'd0, 1'b0);
      check_grant("rst", 6'd0, 3'd0);
      check_output("rst_last", 16'(bus.last_gnt), 16'h20);
      check_output("rst_perr", 16'(bus.ptr_err), 16'h0);
      apply_stimulus(1'b0, 6'd0, 1'b0);
      check_grant("idle", 6'd0, 3'd0);

      // first grant and gapless handover
      apply_stimulus(1'b0, 6'b000101, 1'b0);
      check_grant("first", 6'b000001, 3'd0);
      check_output("first_last", 16'(bus.last_gnt), 16'h01);
      apply_stimulus(1'b0, 6'b000100, 1'b0);
      check_grant("handover", 6'b000100, 3'd2);
      check_output("handover_last", 16'(bus.last_gnt), 16'h04);
      apply_stimulus(1'b0, 6'd0, 1'b0);
      check_grant("release", 6'd0, 3'd0);
      check_output("release_last", 16'(bus.last_gnt), 16'h04);

      // full round-robin rotation, each owner keeps the grant 2 cycles
      apply_stimulus(1'b1, 6'd0, 1'b0);
      apply_stimulus(1'b0, 6'b111111, 1'b0);
      for (int i = 0; i <= 6; i++) begin
         check_grant("rr_a", 6'(1 << (i % 6)), 3'(i % 6));
         apply_stimulus(1'b0, 6'b111111, 1'b0);
         check_grant("rr_b", 6'(1 << (i % 6)), 3'(i % 6));
         apply_stimulus(1'b0, ~6'(1 << (i % 6)), 1'b0);
      end
      check_grant("rr_end", 6'b000010, 3'd1);
      apply_stimulus(1'b0, 6'd0, 1'b0);
      check_grant("rr_idle", 6'd0, 3'd0);
      check_output("rr_idle_last", 16'(bus.last_gnt), 16'h02);

      // max-hold: requestor 3 owns for exactly 4 cycles once requestor 1 waits
      apply_stimulus(1'b0, 6'b001000, 1'b0);
      check_grant("mh_c1", 6'b001000, 3'd3);
      apply_stimulus(1'b0, 6'b001000, 1'b0);
      check_grant("mh_c2", 6'b001000, 3'd3);
      apply_stimulus(1'b0, 6'b001010, 1'b0);
      check_grant("mh_c3", 6'b001000, 3'd3);
      apply_stimulus(1'b0, 6'b001010, 1'b0);
      check_grant("mh_c4", 6'b001000, 3'd3);
      apply_stimulus(1'b0, 6'b001010, 1'b0);
      check_grant("mh_swap", 6'b000010, 3'd1);
      apply_stimulus(1'b0, 6'd0, 1'b0);
      check_grant("mh_idle", 6'd0, 3'd0);

      // no competitor: the owner keeps the grant well past the limit
      held = 0;
      for (int i = 0; i < 300; i++) begin
         apply_stimulus(1'b0, 6'b001000, 1'b0);
         if (bus.gnt === 6'b001000) held++;
      end
      check_output("hold300", 16'(held), 16'd300);
      apply_stimulus(1'b0, 6'd0, 1'b0);
      check_grant("hold_idle", 6'd0, 3'd0);

      // single-cycle pulse from requestor 5
      apply_stimulus(1'b0, 6'b100000, 1'b0);
      check_grant("pulse5", 6'b100000, 3'd5);
      apply_stimulus(1'b0, 6'd0, 1'b0);
      check_grant("pulse5_off", 6'd0, 3'd0);
      check_output("pulse5_last", 16'(bus.last_gnt), 16'h20);

      // pointer corruption and sticky fault
      apply_stimulus(1'b0, 6'b000100, 1'b0);
      apply_stimulus(1'b0, 6'd0, 1'b0);
      check_output("inj_pre_last", 16'(bus.last_gnt), 16'h04);
      apply_stimulus(1'b0, 6'd0, 1'b1);
      check_output("inj_last", 16'(bus.last_gnt), 16'h05);
      check_output("inj_perr0", 16'(bus.ptr_err), 16'h0);
      apply_stimulus(1'b0, 6'd0, 1'b0);
      check_output("inj_perr1", 16'(bus.ptr_err), 16'h1);
      check_output("inj_last_hold", 16'(bus.last_gnt), 16'h05);
      apply_stimulus(1'b0, 6'b000011, 1'b0);
      check_grant("bad_ptr_scan", 6'b000001, 3'd0);
      apply_stimulus(1'b0, 6'd0, 1'b0);
      apply_stimulus(1'b0, 6'd0, 1'b1);
      check_output("zero_ptr", 16'(bus.last_gnt), 16'h00);
      apply_stimulus(1'b0, 6'b000110, 1'b0);
      check_grant("zero_ptr_scan", 6'b000010, 3'd1);
      apply_stimulus(1'b0, 6'd0, 1'b0);
      check_output("perr_sticky", 16'(bus.ptr_err), 16'h1);

      // reset during a grant
      apply_stimulus(1'b0, 6'b010000, 1'b0);
      check_grant("pre_rst", 6'b010000, 3'd4);
      apply_stimulus(1'b1, 6'b110001, 1'b0);
      check_grant("mid_rst", 6'd0, 3'd0);
      check_output("mid_rst_last", 16'(bus.last_gnt), 16'h20);
      check_output("mid_rst_perr", 16'(bus.ptr_err), 16'h0);
      apply_stimulus(1'b1, 6'b110001, 1'b0);
      check_grant("rst_ignores_req", 6'd0, 3'd0);
      apply_stimulus(1'b0, 6'b110001, 1'b0);
      check_grant("post_rst", 6'b000001, 3'd0);
      check_output("post_rst_last", 16'(bus.last_gnt), 16'h01);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
